noc_vc_output_scheduler: RTL

Per-output-port virtual-channel scheduler. Sits between the per-VC output queues of a router and an EXTERNAL-type flit link, which carries one flit bus shared by all VCs. Each cycle it picks one eligible VC by round-robin, gated by that VC's downstream credit (vc_ready). It registers the chosen flit onto the shared link and optionally locks the link to one VC from header to tail.

---
 rtl/noc_vc_output_scheduler_pkg.sv | 27 ++
 rtl/noc_rr_arbiter.sv | 42 ++++
 rtl/noc_vc_output_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/noc_vc_output_scheduler_pkg.sv
// Shared NoC parameters and types for the VC output scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_vc_output_scheduler_pkg;

    localparam int Noc_VC_Channel   = 4;
    localparam int Noc_Data_Width   = 32;
    localparam int Noc_VC_Idx_Width = $clog2(Noc_VC_Channel);

    // SCHED_LOCKED keeps the link on one VC from a header flit until its tail flit.
    typedef enum logic {
        SCHED_ARB    = 1'b0,
        SCHED_LOCKED = 1'b1
    } sched_state_t;

    // Framing bits that travel with every flit.
    typedef struct packed {
        logic hdr;
        logic tail;
    } meta_t;

    // Round-robin successor of a VC index. The result wraps from n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin pick: the first request at or after ptr, wrapping Channel-1 -> 0.
// Latency: purely combinational. The pointer is stored by the parent.
// Backpressure: none. The caller gates req with its own readiness terms.
// Ports: req (per-VC request), ptr (search start), grant (one-hot),
//        grant_idx (index of grant), grant_vld (any grant).
module noc_rr_arbiter
    import noc_vc_output_scheduler_pkg::*;
#(
    parameter int Channel   = Noc_VC_Channel,
    parameter int Idx_Width = Noc_VC_Idx_Width
) (
    input  logic [Channel-1:0]   req,
    input  logic [Idx_Width-1:0] ptr,
    output logic [Channel-1:0]   grant,
    output logic [Idx_Width-1:0] grant_idx,
    output logic                 grant_vld
);

    // cand carries one extra bit so that ptr + i cannot overflow before the wrap.
    logic [Idx_Width:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < Channel; i++) begin
            cand = {1'b0, ptr} + (Idx_Width+1)'(i);
            if (cand >= (Idx_Width+1)'(Channel)) begin
                cand = cand - (Idx_Width+1)'(Channel);
            end
            if (!grant_vld && req[cand[Idx_Width-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[Idx_Width-1:0];
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/noc_vc_output_scheduler.sv
// Per-output-port VC scheduler. It picks one credited VC round-robin and registers its flit onto a shared link.
// Latency: 1 cycle from grant (in_ready) to the flit appearing on out_flit/out_valid.
// Backpressure: the output register holds while out_ready of its VC is low. in_ready is only raised when the register loads.
// Ports: in_valid/in_ready/in_flit/in_is_header/in_is_tail (per-VC queue heads),
//        out_valid (one-hot VC)/out_ready/out_flit/out_is_header/out_is_tail (shared link),
//        out_vc_ready (per-VC downstream credit), protocol_err (sticky framing error).
module noc_vc_output_scheduler
    import noc_vc_output_scheduler_pkg::*;
#(
    parameter int Channel     = Noc_VC_Channel,
    parameter int Data_width  = Noc_Data_Width,
    parameter bit Lock_Packet = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [Channel-1:0]                  in_valid,
    output logic [Channel-1:0]                  in_ready,
    input  logic [Channel-1:0][Data_width-1:0]  in_flit,
    input  logic [Channel-1:0]                  in_is_header,
    input  logic [Channel-1:0]                  in_is_tail,
    output logic [Channel-1:0]                  out_valid,
    input  logic [Channel-1:0]                  out_ready,
    output logic [Data_width-1:0]               out_flit,
    input  logic [Channel-1:0]                  out_vc_ready,
    output logic                                out_is_header,
    output logic                                out_is_tail,
    output logic                                protocol_err
);

    localparam int IdxW = (Channel > 1) ? $clog2(Channel) : 1;

    // Output register
    logic                  out_vld_q;
    logic [IdxW-1:0]       out_vc_q;
    logic [Data_width-1:0] out_flit_q;
    meta_t                 out_meta_q;

    // Scheduling state
    sched_state_t          state_q, state_d;
    logic [IdxW-1:0]       lock_vc_q, lock_vc_d;
    logic [IdxW-1:0]       ptr_q;
    logic [Channel-1:0]    pkt_active_q;
    logic                  protocol_err_q;

    // Datapath
    logic                  fire;
    logic                  load_en;
    logic                  take;
    logic [Channel-1:0]    elig;
    logic [Channel-1:0]    grant;
    logic [IdxW-1:0]       grant_idx;
    logic                  grant_vld;
    logic [Data_width-1:0] grant_flit;
    meta_t                 grant_meta;

    assign fire    = out_vld_q & out_ready[out_vc_q];
    assign load_en = ~out_vld_q | fire;
    assign take    = load_en & grant_vld;

    // While locked, only the owning VC may compete. Credit is checked at grant time only.
    always_comb begin
        elig = '0;
        for (int v = 0; v < Channel; v++) begin
            elig[v] = in_valid[v] & out_vc_ready[v] &
                      ((state_q == SCHED_ARB) | (lock_vc_q == IdxW'(v)));
        end
    end

    noc_rr_arbiter #(
        .Channel   (Channel),
        .Idx_Width (IdxW)
    ) u_rr_arbiter (
        .req       (elig),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign in_ready        = load_en ? grant : '0;
    assign grant_flit      = in_flit[grant_idx];
    assign grant_meta.hdr  = in_is_header[grant_idx];
    assign grant_meta.tail = in_is_tail[grant_idx];

    // Lock FSM. A flit with both header and tail set is a whole packet, so it never locks.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        if (Lock_Packet && take) begin
            case (state_q)
                SCHED_ARB: begin
                    if (grant_meta.hdr && !grant_meta.tail) begin
                        state_d   = SCHED_LOCKED;
                        lock_vc_d = grant_idx;
                    end
                end
                SCHED_LOCKED: begin
                    if (grant_idx == lock_vc_q && grant_meta.tail) begin
                        state_d = SCHED_ARB;
                    end
                end
                default: state_d = SCHED_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCHED_ARB;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    // Output register. When it loads without a grant it empties, so a fired flit is not replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_vc_q   <= '0;
            out_flit_q <= '0;
            out_meta_q <= '0;
        end else if (load_en) begin
            out_vld_q <= grant_vld;
            if (grant_vld) begin
                out_vc_q   <= grant_idx;
                out_flit_q <= grant_flit;
                out_meta_q <= grant_meta;
            end
        end
    end

    // The pointer moves past the granted VC. Idle cycles leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (take) begin
            ptr_q <= IdxW'(rr_next(int'(grant_idx), Channel));
        end
    end

    // Framing check. A header is legal only on an idle VC, and a non-header only mid-packet.
    // The two error cases reduce to hdr == pkt_active. The flit is forwarded either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_active_q   <= '0;
            protocol_err_q <= 1'b0;
        end else if (take) begin
            if (grant_meta.hdr == pkt_active_q[grant_idx]) begin
                protocol_err_q <= 1'b1;
            end
            if (grant_meta.tail) begin
                pkt_active_q[grant_idx] <= 1'b0;
            end else if (grant_meta.hdr) begin
                pkt_active_q[grant_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        if (out_vld_q) begin
            out_valid[out_vc_q] = 1'b1;
        end
    end

    assign out_flit      = out_flit_q;
    assign out_is_header = out_meta_q.hdr;
    assign out_is_tail   = out_meta_q.tail;
    assign protocol_err  = protocol_err_q;

endmodule
